lc3_isdu_ctrl: RTL and testbench

Moore-style instruction sequencer for the LC-3 datapath. It runs fetch/decode/execute for the lab instruction subset and drives every load enable, gate and mux select in the datapath, including LD_CC and LD_BEN for the branch-enable/condition-code register. It consumes that register's registered BEN output to resolve BR. It sits between the IR/BEN registers and the datapath control inputs.

---
 rtl/lc3_isdu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lc3_isdu_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_isdu_ctrl.sv
// LC-3 instruction sequencer (Moore FSM) for the lab instruction subset.
// Produces every datapath load enable, bus gate and mux select from the
// state register, and sequences fetch/decode/execute.
// Optional build macro: ISDU_JSR_EN. Defining it adds the JSR/JSRR states
// (S04, S21). Without it, opcode 0100 executes as a NOP.
module lc3_isdu_ctrl #(
    parameter int MEM_WAIT = 3        // cycles per memory access state, 1..15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [4:0] HALTED    = 5'd0,
                           S18       = 5'd1,
                           S33       = 5'd2,
                           S35       = 5'd3,
                           PAUSE_IR1 = 5'd4,
                           PAUSE_IR2 = 5'd5,
                           S32       = 5'd6,
                           S01       = 5'd7,
                           S05       = 5'd8,
                           S09       = 5'd9,
                           S00       = 5'd10,
                           S22       = 5'd11,
                           S12       = 5'd12,
                           S04       = 5'd13,
                           S21       = 5'd14,
                           S06       = 5'd15,
                           S07       = 5'd16,
                           S25       = 5'd17,
                           S27       = 5'd18,
                           S23       = 5'd19,
                           S16       = 5'd20,
                           PAUSE1    = 5'd21,
                           PAUSE2    = 5'd22;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    logic [4:0] state, nxt;
    logic [3:0] cnt;
    logic       wait_done;
    logic       wait_entry;

    // cnt counts down the remaining cycles of the current memory state
    assign wait_done  = (cnt == 4'd0);
    assign wait_entry = (nxt != state) && (nxt == S33 || nxt == S25 || nxt == S16);

`ifndef ISDU_JSR_EN
    logic unused_ir11;
    assign unused_ir11 = IR_11;
`endif

    // state register and memory wait counter, synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= HALTED;
            cnt   <= 4'd0;
        end else begin
            state <= nxt;
            if (wait_entry)
                cnt <= WAIT_LOAD;
            else if (!wait_done)
                cnt <= cnt - 4'd1;
        end
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            HALTED:    if (Run) nxt = S18;
            S18:       nxt = S33;
            S33:       if (wait_done) nxt = S35;
            S35:       nxt = PAUSE_IR1;
            PAUSE_IR1: if (Continue) nxt = PAUSE_IR2;
            PAUSE_IR2: if (!Continue) nxt = S32;
            S32: begin
                case (Opcode)
                    4'b0001: nxt = S01;
                    4'b0101: nxt = S05;
                    4'b1001: nxt = S09;
                    4'b0000: nxt = S00;
                    4'b1100: nxt = S12;
`ifdef ISDU_JSR_EN
                    4'b0100: nxt = S04;
`endif
                    4'b0110: nxt = S06;
                    4'b0111: nxt = S07;
                    4'b1101: nxt = PAUSE1;
                    default: nxt = S18;
                endcase
            end
            S00:       nxt = BEN ? S22 : S18;
`ifdef ISDU_JSR_EN
            S04:       nxt = S21;
`endif
            S06:       nxt = S25;
            S07:       nxt = S23;
            S25:       if (wait_done) nxt = S27;
            S23:       nxt = S16;
            S16:       if (wait_done) nxt = S18;
            PAUSE1:    if (Continue) nxt = PAUSE2;
            PAUSE2:    if (!Continue) nxt = S18;
            default:   nxt = S18;     // S01/S05/S09/S22/S12/S21/S27 and strays
        endcase
    end

    // output decode; everything defaults low
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ADDR1MUX = 1'b0; DRMUX = 1'b0;
        SR1MUX = 1'b0; SR2MUX = 1'b0; ALUK = 2'b00;
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        case (state)
            S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            S33, S25: begin Mem_OE = 1'b1; LD_MDR = wait_done; end
            S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
            PAUSE_IR1, PAUSE1: LD_LED = 1'b1;
            S32: LD_BEN = 1'b1;
            S01, S05, S09: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                SR2MUX  = (state != S09) ? IR_5 : 1'b0;
                ALUK    = (state == S01) ? 2'b00 : (state == S05) ? 2'b01 : 2'b10;
            end
            S22: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b10; end
            S12: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR1MUX = 1'b1; end
`ifdef ISDU_JSR_EN
            S04: begin GatePC = 1'b1; LD_REG = 1'b1; DRMUX = 1'b1; end
            S21: begin
                LD_PC = 1'b1; PCMUX = 2'b10;
                ADDR1MUX = ~IR_11;
                ADDR2MUX = IR_11 ? 2'b11 : 2'b00;
            end
`endif
            S06, S07: begin
                GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
            end
            S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            S23: begin SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
            S16: Mem_WE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_isdu_ctrl.sv
// Directed bench for lc3_isdu_ctrl (MEM_WAIT=3). Outputs are packed into one
// vector and compared cycle by cycle against hand-built expected sequences.
module tb_lc3_isdu_ctrl;
    logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic ADDR1MUX, DRMUX, SR1MUX, SR2MUX, Mem_OE, Mem_WE;

    int vec = 0, errs = 0;

    lc3_isdu_ctrl #(.MEM_WAIT(3)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    logic [23:0] sig;
    assign sig = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX,
                  ADDR1MUX, DRMUX, SR1MUX, SR2MUX, ALUK, Mem_OE, Mem_WE};

    localparam logic [23:0] B_LDMAR = 24'h800000, B_LDMDR = 24'h400000,
        B_LDIR = 24'h200000, B_LDBEN = 24'h100000, B_LDCC = 24'h080000,
        B_LDREG = 24'h040000, B_LDPC = 24'h020000, B_LDLED = 24'h010000,
        B_GPC = 24'h008000, B_GMDR = 24'h004000, B_GALU = 24'h002000,
        B_GMARMUX = 24'h001000, B_PCMUX_ADR = 24'h000800,
        B_A2_OFF6 = 24'h000100, B_A2_OFF9 = 24'h000200, B_A2_OFF11 = 24'h000300,
        B_A1_SR1 = 24'h000080, B_DR_R7 = 24'h000040, B_SR1_11 = 24'h000020,
        B_SR2_IMM = 24'h000010, B_ALU_AND = 24'h000004, B_ALU_PASS = 24'h00000C,
        B_OE = 24'h000002, B_WE = 24'h000001;

    localparam logic [23:0] E_S18 = B_LDMAR | B_LDPC | B_GPC;
    localparam logic [23:0] E_S27 = B_GMDR | B_LDREG | B_LDCC;
    localparam logic [23:0] E_S07 = B_GMARMUX | B_LDMAR | B_A1_SR1 | B_A2_OFF6;
    localparam logic [23:0] E_S23 = B_SR1_11 | B_ALU_PASS | B_GALU | B_LDMDR;

    task automatic step();
        @(posedge Clk); #1;
    endtask

    // Walk S18 -> S33 x3 -> S35 -> PAUSE_IR1 -> PAUSE_IR2 -> S32, starting in S18
    task automatic test_fetch(input string nm);
        logic [23:0] e[9] = '{B_OE, B_OE, B_OE | B_LDMDR, B_GMDR | B_LDIR,
                              B_LDLED, B_LDLED, 24'h0, 24'h0, B_LDBEN};
        bit c[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            Continue = c[i];
            step();
            vec++;
            if (sig !== e[i]) begin
                errs++;
                $display("FAIL %s fetch[%0d]: got %h want %h", nm, i, sig, e[i]);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0;
        step(); step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL reset_outputs: got %h want 0", sig); end
        Reset = 1'b0;
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL halted_hold: got %h want 0", sig); end
        Run = 1'b1;
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL run_s18: got %h want %h", sig, E_S18); end
    endtask

    // Run stays high from here on; it must be ignored outside HALTED
    task automatic test_alu();
        Opcode = 4'b0001; IR_5 = 1'b0;
        test_fetch("add");
        step();
        vec++; if (sig !== (B_GALU | B_LDREG | B_LDCC))
            begin errs++; $display("FAIL add_s01: got %h want %h", sig, B_GALU | B_LDREG | B_LDCC); end
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL add_back_s18: got %h want %h", sig, E_S18); end
        Opcode = 4'b0101; IR_5 = 1'b1;
        test_fetch("and");
        step();
        vec++; if (sig !== (B_GALU | B_LDREG | B_LDCC | B_SR2_IMM | B_ALU_AND))
            begin errs++; $display("FAIL and_imm_s05: got %h", sig); end
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL and_back_s18: got %h want %h", sig, E_S18); end
    endtask

    task automatic test_br();
        Opcode = 4'b0000; IR_5 = 1'b0;
        test_fetch("br_taken");
        BEN = 1'b1;
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL br_s00: got %h want 0", sig); end
        step();
        vec++; if (sig !== (B_LDPC | B_PCMUX_ADR | B_A2_OFF9))
            begin errs++; $display("FAIL br_s22: got %h want %h", sig, B_LDPC | B_PCMUX_ADR | B_A2_OFF9); end
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL br_back_s18: got %h want %h", sig, E_S18); end
        test_fetch("br_not");
        BEN = 1'b0;
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL brn_s00: got %h want 0", sig); end
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL brn_s18: got %h want %h", sig, E_S18); end
    endtask

    task automatic test_str();
        logic [23:0] e[6] = '{E_S07, E_S23, B_WE, B_WE, B_WE, E_S18};
        Opcode = 4'b0111;
        test_fetch("str");
        for (int i = 0; i < 6; i++) begin
            step();
            vec++;
            if (sig !== e[i]) begin errs++; $display("FAIL str[%0d]: got %h want %h", i, sig, e[i]); end
        end
    endtask

    task automatic test_ldr();
        logic [23:0] e[6] = '{E_S07, B_OE, B_OE, B_OE | B_LDMDR, E_S27, E_S18};
        Opcode = 4'b0110;
        test_fetch("ldr");
        for (int i = 0; i < 6; i++) begin
            step();
            vec++;
            if (sig !== e[i]) begin errs++; $display("FAIL ldr[%0d]: got %h want %h", i, sig, e[i]); end
        end
    endtask

    task automatic test_pause_and_illegal();
        Opcode = 4'b1101;
        test_fetch("pause");
        Continue = 1'b1;
        step();
        vec++; if (sig !== B_LDLED) begin errs++; $display("FAIL pause1: got %h want %h", sig, B_LDLED); end
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL pause1_exit: got %h want 0", sig); end
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL pause2_hold: got %h want 0", sig); end
        Continue = 1'b0;
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL pause2_s18: got %h want %h", sig, E_S18); end
        Opcode = 4'b1111;
        test_fetch("illegal");
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL illegal_s18: got %h want %h", sig, E_S18); end
    endtask

    task automatic test_jsr();
        Opcode = 4'b0100; IR_11 = 1'b1;
        test_fetch("jsr");
        step();
`ifdef ISDU_JSR_EN
        vec++; if (sig !== (B_GPC | B_LDREG | B_DR_R7))
            begin errs++; $display("FAIL jsr_s04: got %h want %h", sig, B_GPC | B_LDREG | B_DR_R7); end
        step();
        vec++; if (sig !== (B_LDPC | B_PCMUX_ADR | B_A2_OFF11))
            begin errs++; $display("FAIL jsr_s21: got %h want %h", sig, B_LDPC | B_PCMUX_ADR | B_A2_OFF11); end
        step();
`endif
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL jsr_s18: got %h want %h", sig, E_S18); end
    endtask

    task automatic test_reset_during_write();
        Opcode = 4'b0111;
        test_fetch("str_rst");
        step(); step(); step();
        vec++; if (sig !== B_WE) begin errs++; $display("FAIL rst_pre_we: got %h want %h", sig, B_WE); end
        Reset = 1'b1;
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL rst_we_drop: got %h want 0", sig); end
        Reset = 1'b0; Run = 1'b0;
        step();
        vec++; if (sig !== 24'h0) begin errs++; $display("FAIL rst_halted: got %h want 0", sig); end
        Run = 1'b1;
        step();
        vec++; if (sig !== E_S18) begin errs++; $display("FAIL rst_run_s18: got %h want %h", sig, E_S18); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_br();
        test_str();
        test_ldr();
        test_pause_and_illegal();
        test_jsr();
        test_reset_during_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
